fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage with a decoupling prefetch queue. It sits between the instruction memory and the decode stage. It issues sequential word fetches to a synchronous 1-cycle-latency instruction memory and buffers returned instructions with their PC+4 in a first-word-fall-through queue. It applies branch/jump redirects and flushes, and supports single-step debug mode, where delivery is gated by rising edges of a step input.

---
 rtl/fetch_prefetch_unit_pkg.sv | 9 +
 rtl/fetch_prefetch_unit_queue.sv | 59 +++++
 rtl/fetch_prefetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared defaults for the fetch stage and its prefetch queue.
package fetch_prefetch_unit_pkg;

    localparam int          NB_BITS           = 32;
    localparam logic [31:0] NOP_OPERATION     = 32'h0000_0000;
    localparam int          FETCH_QUEUE_DEPTH = 4;
    localparam int          IMEM_ADDR_BITS    = 10;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// First-word-fall-through FIFO holding fetched {pc+4, instr} pairs.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0) && !i_clear;
    assign w_push = i_push && !i_clear && ((r_count != FULL) || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: sequential prefetch, redirects, flush, step mode.
module fetch_prefetch_unit #(
    parameter int          NB_BITS     = fetch_prefetch_unit_pkg::NB_BITS,
    parameter int          NB_ADDR     = fetch_prefetch_unit_pkg::IMEM_ADDR_BITS,
    parameter int          QUEUE_DEPTH = fetch_prefetch_unit_pkg::FETCH_QUEUE_DEPTH,
    parameter logic [31:0] NOP         = fetch_prefetch_unit_pkg::NOP_OPERATION
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    output logic                           o_imem_en,
    output logic [NB_ADDR-1:0]             o_imem_addr,
    input  logic [NB_BITS-1:0]             i_imem_data,
    output logic [NB_BITS-1:0]             o_if_id_instr,
    output logic [NB_BITS-1:0]             o_if_id_pc,
    output logic                           o_if_id_valid,
    output logic [NB_BITS-1:0]             o_pc_debug,
    output logic [$clog2(QUEUE_DEPTH):0]   o_queue_count,
    input  logic [NB_BITS-1:0]             i_brq_addr,
    input  logic [NB_BITS-1:0]             i_jmp_addr,
    input  logic                           i_ctr_beq,
    input  logic                           i_ctr_jmp,
    input  logic                           i_ctr_flush,
    input  logic                           i_pc_we,
    input  logic                           i_if_id_we,
    input  logic                           i_debug,
    input  logic                           i_step
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [NB_BITS-1:0]   r_pc;
    logic [NB_BITS-1:0]   r_inflight_pc;
    logic                 r_inflight;
    logic                 r_step_prev;

    logic                 w_gate;
    logic                 w_redirect;
    logic                 w_kill;
    logic [NB_BITS-1:0]   w_target;
    logic [CW-1:0]        w_count;
    logic                 w_empty;
    logic [2*NB_BITS-1:0] w_head;
    logic [NB_BITS-1:0]   w_head_pc;
    logic [NB_BITS-1:0]   w_head_instr;
    logic [CW:0]          w_used;
    logic                 w_credit;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [NB_BITS-1:0]   w_pc_next;

    assign w_gate     = !i_debug || (i_step && !r_step_prev);
    assign w_redirect = i_ctr_jmp || i_ctr_beq;
    assign w_kill     = w_redirect || i_ctr_flush;
    assign w_target   = i_ctr_jmp ? i_jmp_addr : i_brq_addr;

    // Count queued plus in-flight words so a return can never overflow.
    assign w_used   = {1'b0, w_count} + (CW+1)'(r_inflight);
    assign w_credit = w_used < (CW+1)'(QUEUE_DEPTH);
    assign w_issue  = !i_rst && w_gate && i_pc_we && !w_kill && w_credit;

    assign w_push = r_inflight && !w_kill;
    assign w_pop  = !w_empty && i_if_id_we && w_gate && !w_kill;

    assign w_head_pc    = w_head[2*NB_BITS-1 -: NB_BITS];
    assign w_head_instr = w_head[NB_BITS-1:0];

    // Flush resumes at the oldest word that was discarded.
    always_comb begin
        w_pc_next = r_pc;
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (i_ctr_flush) begin
            if (!w_empty)        w_pc_next = w_head_pc - NB_BITS'(4);
            else if (r_inflight) w_pc_next = r_inflight_pc;
        end else if (w_issue) begin
            w_pc_next = r_pc + NB_BITS'(4);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_step_prev   <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_inflight  <= w_issue;
            r_step_prev <= i_step;
            if (w_issue) r_inflight_pc <= r_pc;
        end
    end

    fetch_queue #(
        .WIDTH (2*NB_BITS),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_kill),
        .i_data  ({r_inflight_pc + NB_BITS'(4), i_imem_data}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign o_imem_en     = w_issue;
    assign o_imem_addr   = r_pc[NB_ADDR+1:2];
    assign o_if_id_valid = !w_empty;
    assign o_if_id_instr = w_empty ? NOP[NB_BITS-1:0] : w_head_instr;
    assign o_if_id_pc    = w_empty ? '0 : w_head_pc;
    assign o_pc_debug    = r_pc;
    assign o_queue_count = w_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: vector table, directed corners, random vs model.
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] id_pc;
    logic        valid;
    logic [31:0] pc_dbg;
    logic [2:0]  qcount;
    logic [31:0] brq;
    logic [31:0] jaddr;
    logic        beq;
    logic        jmp;
    logic        flush;
    logic        pc_we;
    logic        if_we;
    logic        debug;
    logic        step;

    fetch_prefetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_en     (imem_en),
        .o_imem_addr   (imem_addr),
        .i_imem_data   (imem_data),
        .o_if_id_instr (instr),
        .o_if_id_pc    (id_pc),
        .o_if_id_valid (valid),
        .o_pc_debug    (pc_dbg),
        .o_queue_count (qcount),
        .i_brq_addr    (brq),
        .i_jmp_addr    (jaddr),
        .i_ctr_beq     (beq),
        .i_ctr_jmp     (jmp),
        .i_ctr_flush   (flush),
        .i_pc_we       (pc_we),
        .i_if_id_we    (if_we),
        .i_debug       (debug),
        .i_step        (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [9:0] a);
        return 32'h1000_0000 | {22'h0, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_data <= memf(imem_addr);
    end

    typedef struct {
        bit          rst;
        bit          pc_we;
        bit          if_we;
        bit          beq;
        bit          jmp;
        bit          flush;
        bit          debug;
        bit          step;
        logic [31:0] brq;
        logic [31:0] jaddr;
    } in_t;

    typedef struct {
        bit pc_we;
        bit if_we;
        bit e_en;
        int e_addr;
        bit e_valid;
        int e_k;
        int e_pc;
        int e_count;
        int e_pcdbg;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int n_checks = 0;
    int n_pass   = 0;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_infl;
    bit          m_sprev;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic in_t idle(input bit pw, input bit iw);
        in_t v;
        v = '{default: 0};
        v.pc_we = pw;
        v.if_we = iw;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = '0;
        m_ipc   = '0;
        m_infl  = 1'b0;
        m_sprev = 1'b0;
    endtask

    task automatic drive(input in_t v);
        @(posedge clk);
        #1;
        rst   = v.rst;
        pc_we = v.pc_we;
        if_we = v.if_we;
        beq   = v.beq;
        jmp   = v.jmp;
        flush = v.flush;
        debug = v.debug;
        step  = v.step;
        brq   = v.brq;
        jaddr = v.jaddr;
        @(negedge clk);
    endtask

    // Abstract model: a list of fetched words plus one outstanding request.
    task automatic model_step();
        bit          gate;
        bit          redir;
        bit          kill;
        bit          issue;
        bit          mv;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        ent_t        e;
        if (rst) begin
            chk("rst_ctl", {imem_en, valid, qcount}, {1'b0, 1'b0, 3'd0});
            chk("rst_if", {instr, id_pc}, 64'h0);
            chk("rst_pc", pc_dbg, 32'h0);
            model_reset();
            return;
        end
        gate  = !debug || (step && !m_sprev);
        redir = jmp || beq;
        kill  = redir || flush;
        mv    = mq.size() > 0;
        issue = gate && pc_we && !kill && (mq.size() + int'(m_infl) < DEPTH);
        e_ins = mv ? mq[0].ins : 32'h0;
        e_pc  = mv ? mq[0].pc : 32'h0;
        chk("m_ctl", {imem_en, imem_addr, valid, qcount},
            {issue, m_pc[11:2], mv, 3'(mq.size())});
        chk("m_instr", instr, e_ins);
        chk("m_ifpc", id_pc, e_pc);
        chk("m_pcdbg", pc_dbg, m_pc);
        if (kill) begin
            if (redir)      m_pc = jmp ? jaddr : brq;
            else if (mv)    m_pc = mq[0].pc - 32'd4;
            else if (m_infl) m_pc = m_ipc;
            mq.delete();
            m_infl = 1'b0;
        end else begin
            if (mv && if_we && gate) void'(mq.pop_front());
            if (m_infl) begin
                e.pc  = m_ipc + 32'd4;
                e.ins = memf(m_ipc[11:2]);
                mq.push_back(e);
            end
            m_infl = issue;
            if (issue) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
        m_sprev = step;
    endtask

    vec_t tbl[14];
    in_t  v;
    int   issues;
    logic [31:0] pc0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 1, 1, 0, 0, 0, 0,  0, 0};
        tbl[1]  = '{1, 1, 1, 1, 0, 0, 0,  0, 4};
        tbl[2]  = '{1, 1, 1, 2, 1, 0, 4,  1, 8};
        tbl[3]  = '{1, 1, 1, 3, 1, 1, 8,  1, 12};
        tbl[4]  = '{1, 0, 1, 4, 1, 2, 12, 1, 16};
        tbl[5]  = '{1, 0, 1, 5, 1, 2, 12, 2, 20};
        tbl[6]  = '{1, 0, 0, 6, 1, 2, 12, 3, 24};
        tbl[7]  = '{1, 0, 0, 6, 1, 2, 12, 4, 24};
        tbl[8]  = '{1, 0, 0, 6, 1, 2, 12, 4, 24};
        tbl[9]  = '{1, 1, 0, 6, 1, 2, 12, 4, 24};
        tbl[10] = '{1, 1, 1, 6, 1, 3, 16, 3, 24};
        tbl[11] = '{1, 1, 1, 7, 1, 4, 20, 2, 28};
        tbl[12] = '{1, 1, 1, 8, 1, 5, 24, 2, 32};
        tbl[13] = '{1, 1, 1, 9, 1, 6, 28, 2, 36};

        rst = 1'b1; pc_we = 0; if_we = 0; beq = 0; jmp = 0; flush = 0;
        debug = 0; step = 0; brq = 0; jaddr = 0; imem_data = 0;
        model_reset();
        v = idle(0, 0);
        v.rst = 1;
        repeat (3) begin
            drive(v);
            model_step();
        end

        foreach (tbl[i]) begin
            drive(idle(tbl[i].pc_we, tbl[i].if_we));
            chk($sformatf("tbl%0d_en", i), imem_en, tbl[i].e_en);
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_instr", i), instr,
                tbl[i].e_valid ? memf(10'(tbl[i].e_k)) : 32'h0);
            chk($sformatf("tbl%0d_ifpc", i), id_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_cnt", i), qcount, tbl[i].e_count);
            chk($sformatf("tbl%0d_pcdbg", i), pc_dbg, tbl[i].e_pcdbg);
            model_step();
        end

        drive(idle(1, 0));
        model_step();
        v = idle(1, 0);
        v.jmp = 1;
        v.jaddr = 32'h40;
        drive(v);
        chk("jmp_pre_cnt", qcount, 3);
        model_step();
        drive(idle(1, 0));
        chk("jmp_n1_cnt", qcount, 0);
        chk("jmp_n1_addr", {imem_en, imem_addr}, {1'b1, 10'h10});
        model_step();
        drive(idle(1, 0));
        chk("jmp_n2_valid", valid, 0);
        model_step();
        drive(idle(1, 0));
        chk("jmp_n3_head", {valid, id_pc, instr}, {1'b1, 32'h44, memf(10'h10)});
        model_step();

        v = idle(1, 1);
        v.beq = 1; v.jmp = 1; v.brq = 32'h80; v.jaddr = 32'h100;
        drive(v);
        model_step();
        drive(idle(1, 1));
        chk("both_pc", pc_dbg, 32'h100);
        model_step();

        v = idle(1, 0);
        v.jmp = 1; v.jaddr = 32'h20;
        drive(v);
        model_step();
        repeat (4) begin
            drive(idle(1, 0));
            model_step();
        end
        v = idle(1, 0);
        v.flush = 1;
        drive(v);
        chk("flush_head", id_pc, 32'h24);
        model_step();
        drive(idle(1, 0));
        chk("flush_cnt", qcount, 0);
        chk("flush_issue", {imem_en, imem_addr}, {1'b1, 10'h8});
        model_step();

        v = idle(1, 1);
        v.debug = 1; v.flush = 1;
        drive(v);
        model_step();
        v = idle(1, 1);
        v.debug = 1;
        drive(v);
        pc0 = pc_dbg;
        model_step();
        issues = 0;
        for (int k = 0; k < 10; k++) begin
            v = idle(1, 1);
            v.debug = 1;
            v.step = (k < 5) || (k == 6) || (k == 8);
            drive(v);
            if (imem_en) issues++;
            model_step();
        end
        chk("dbg_issues", issues, 3);
        chk("dbg_pc", pc_dbg, pc0 + 32'd12);

        for (int k = 0; k < 400; k++) begin
            v.rst   = 0;
            v.pc_we = $urandom_range(0, 99) < 85;
            v.if_we = $urandom_range(0, 99) < 70;
            v.beq   = $urandom_range(0, 99) < 5;
            v.jmp   = $urandom_range(0, 99) < 4;
            v.flush = $urandom_range(0, 99) < 4;
            v.debug = ((k / 50) % 3) == 2;
            v.step  = 1'($urandom_range(0, 1));
            v.brq   = $urandom;
            v.jaddr = $urandom;
            drive(v);
            model_step();
        end

        drive(idle(1, 1));
        model_step();
        v = idle(1, 1);
        v.rst = 1;
        drive(v);
        model_step();
        repeat (6) begin
            drive(idle(1, 1));
            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
